// File: rtl/dma_multi_channel.sv
// Multi-channel DMA: NCH request channels share one read and one write port.
// A round-robin arbiter grants a whole job at a time; each word is a read then a write.
module dma_multi_channel #(
    parameter int NCH    = 2,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 4,
    parameter int DATA_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCH-1:0]          start,
    input  logic [NCH*ADDR_W-1:0]   src_addr,
    input  logic [NCH*ADDR_W-1:0]   dst_addr,
    input  logic [NCH*LEN_W-1:0]    len,
    output logic                    rd_en,
    output logic [ADDR_W-1:0]       rd_addr,
    input  logic [DATA_W-1:0]       rd_data,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [DATA_W-1:0]       wr_data,
    output logic [NCH-1:0]          busy,
    output logic [NCH-1:0]          done
);

    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [NCH-1:0]      r_pending;
    logic [ADDR_W-1:0]   r_src [NCH];
    logic [ADDR_W-1:0]   r_dst [NCH];
    logic [LEN_W-1:0]    r_len [NCH];
    logic [CH_W-1:0]     r_last_grant;
    logic [CH_W-1:0]     r_grant;
    logic [ADDR_W-1:0]   r_cur_src;
    logic [ADDR_W-1:0]   r_cur_dst;
    logic [LEN_W-1:0]    r_cur_cnt;
    logic [CH_W-1:0]     w_grant;
    logic                w_found;
    logic [NCH-1:0]      w_clear;

    // Round-robin search starting just after the last channel served.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < NCH; k++) begin
            if (!w_found && r_pending[(int'(r_last_grant) + 1 + k) % NCH]) begin
                w_found = 1'b1;
                w_grant = CH_W'((int'(r_last_grant) + 1 + k) % NCH);
            end
        end
    end

    always_comb begin
        busy = r_pending;
        if (r_state == S_READ || r_state == S_WRITE)
            busy[r_grant] = 1'b1;
    end

    // NOTE: the request shadow registers hold data only, so they carry no reset;
    // pending[] alone decides whether their contents mean anything.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCH; i++) begin
            if (start[i] && !busy[i]) begin
                r_src[i] <= src_addr[i*ADDR_W +: ADDR_W];
                r_dst[i] <= dst_addr[i*ADDR_W +: ADDR_W];
                r_len[i] <= len[i*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        w_clear = '0;
        if (r_state == S_IDLE && w_found && r_len[w_grant] == '0)
            w_clear[w_grant] = 1'b1;
        if (r_state == S_WRITE && r_cur_cnt == LEN_W'(1))
            w_clear[r_grant] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (start[i] && !busy[i])
                    r_pending[i] <= 1'b1;
                else if (w_clear[i])
                    r_pending[i] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant <= CH_W'(NCH - 1);
            r_grant      <= '0;
            r_cur_src    <= '0;
            r_cur_dst    <= '0;
            r_cur_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant   <= w_grant;
                        r_cur_src <= r_src[w_grant];
                        r_cur_dst <= r_dst[w_grant];
                        r_cur_cnt <= r_len[w_grant];
                    end
                end
                S_WRITE: begin
                    r_cur_cnt <= r_cur_cnt - LEN_W'(1);
                    r_cur_src <= r_cur_src + ADDR_W'(1);
                    r_cur_dst <= r_cur_dst + ADDR_W'(1);
                end
                S_DONE:  r_last_grant <= r_grant;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next  = r_state;
        rd_en   = 1'b0;
        rd_addr = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        done    = '0;
        case (r_state)
            S_IDLE: begin
                if (w_found)
                    w_next = (r_len[w_grant] == '0) ? S_DONE : S_READ;
            end
            S_READ: begin
                rd_en   = 1'b1;
                rd_addr = r_cur_src;
                w_next  = S_WRITE;
            end
            S_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = r_cur_dst;
                wr_data = rd_data;
                w_next  = (r_cur_cnt == LEN_W'(1)) ? S_DONE : S_READ;
            end
            S_DONE: begin
                done[r_grant] = 1'b1;
                w_next        = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dma_multi_channel.sv
// Directed bench for dma_multi_channel (NCH=2): single job, simultaneous starts,
// round-robin fairness, address wrap, zero length, ignored start and mid-job reset.
module tb_dma_multi_channel;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [7:0]  len;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [1:0]  busy;
    logic [1:0]  done;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    int          n_tests = 0;
    int          n_fail  = 0;

    dma_multi_channel #(.NCH(2), .ADDR_W(8), .LEN_W(4), .DATA_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .len      (len),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Synchronous memory with 1-cycle read latency.
    always @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [7:0] s, input logic [7:0] d, input logic [3:0] l);
        src_addr[ch*8 +: 8] = s;
        dst_addr[ch*8 +: 8] = d;
        len[ch*4 +: 4]      = l;
    endtask

    // Entered in the grant (IDLE) cycle, returns in the done cycle.
    task automatic expect_job(input int ch, input logic [7:0] src, input logic [7:0] dst, input int n);
        logic [7:0] a_s;
        logic [7:0] a_d;
        logic [7:0] exp_d;
        logic [1:0] exp_done;
        check("grant_busy", busy[ch], 1);
        check("grant_strobes", {rd_en, wr_en}, 0);
        tick();
        start = '0;
        for (int k = 0; k < n; k++) begin
            a_s = src + 8'(k);
            a_d = dst + 8'(k);
            check("rd_en", rd_en, 1);
            check("rd_addr", rd_addr, a_s);
            check("rd_wr_excl", wr_en, 0);
            tick();
            exp_d = ref_mem[a_s];
            check("wr_en", wr_en, 1);
            check("wr_rd_excl", rd_en, 0);
            check("wr_addr", wr_addr, a_d);
            check("wr_data", wr_data, exp_d);
            check("busy_active", busy[ch], 1);
            check("no_early_done", done, 0);
            ref_mem[a_d] = exp_d;
            tick();
        end
        exp_done = 2'b01 << ch;
        check("done_pulse", done, exp_done);
        check("busy_in_done", busy[ch], 0);
        check("done_strobes", {rd_en, wr_en}, 0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'hA5;
            ref_mem[i] = 8'(i) ^ 8'hA5;
        end
        reset    = 1'b1;
        start    = '0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
        tick();
        tick();
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // Single job on ch0, start in cycle 0.
        reset = 1'b0;
        set_ch(0, 8'h10, 8'h40, 4'd4);
        start = 2'b01;
        tick();
        expect_job(0, 8'h10, 8'h40, 4);
        for (int k = 0; k < 4; k++)
            check("copy_mem", mem[8'h40 + k], ref_mem[8'h40 + k]);
        tick();
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);

        // Simultaneous starts after reset: ch0 then ch1, twice.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_ch(0, 8'h20, 8'h50, 4'd2);
        set_ch(1, 8'h30, 8'h60, 4'd2);
        start = 2'b11;
        tick();
        check("both_pending", busy, 2'b11);
        expect_job(0, 8'h20, 8'h50, 2);
        tick();
        expect_job(1, 8'h30, 8'h60, 2);
        start = 2'b11;
        tick();
        expect_job(0, 8'h20, 8'h50, 2);
        tick();
        expect_job(1, 8'h30, 8'h60, 2);

        // Fairness plus ignored re-start: ch1 queued during ch0's job goes before ch0's second job.
        set_ch(0, 8'h70, 8'h78, 4'd2);
        start = 2'b01;
        tick();
        set_ch(0, 8'hAA, 8'hBB, 4'd3);
        set_ch(1, 8'h90, 8'h98, 4'd1);
        start = 2'b11;
        expect_job(0, 8'h70, 8'h78, 2);
        set_ch(0, 8'h74, 8'h7C, 4'd1);
        start = 2'b01;
        tick();
        expect_job(1, 8'h90, 8'h98, 1);
        tick();
        expect_job(0, 8'h74, 8'h7C, 1);

        // Zero-length job: done two cycles after start, no strobes.
        set_ch(1, 8'h00, 8'h00, 4'd0);
        start = 2'b10;
        tick();
        expect_job(1, 8'h00, 8'h00, 0);

        // Address wrap on both ports.
        set_ch(0, 8'hFE, 8'hFF, 4'd3);
        start = 2'b01;
        tick();
        expect_job(0, 8'hFE, 8'hFF, 3);

        // Reset in cycle 5 of a len=4 job, with ch0 queued.
        set_ch(1, 8'hB0, 8'hC0, 4'd4);
        start = 2'b10;
        tick();
        start = '0;
        tick();
        set_ch(0, 8'h11, 8'h22, 4'd2);
        start = 2'b01;
        tick();
        start = '0;
        check("queued_busy", busy, 2'b11);
        tick();
        tick();
        check("cycle5_write", wr_en, 1);
        reset = 1'b1;
        tick();
        check("abort_rd_en", rd_en, 0);
        check("abort_rd_addr", rd_addr, 0);
        check("abort_wr_en", wr_en, 0);
        check("abort_wr_addr", wr_addr, 0);
        check("abort_wr_data", wr_data, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        reset = 1'b0;
        tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);
        check("post_rst_strobes", {rd_en, wr_en}, 0);
        set_ch(0, 8'h80, 8'h88, 4'd1);
        set_ch(1, 8'h84, 8'h8C, 4'd1);
        start = 2'b11;
        tick();
        expect_job(0, 8'h80, 8'h88, 1);
        tick();
        expect_job(1, 8'h84, 8'h8C, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_multi_channel.md
# dma_multi_channel

Parametrised multi-channel successor to the single-channel DMA controller: NCH independent channels, each with its own source address, destination address and length, share one memory read port and one memory write port. A round-robin arbiter grants one whole job at a time. Each word is a read followed by a write of the returned data. The block sits between per-channel request logic and a single-port synchronous memory with 1-cycle read latency.

## Interface
- NCH, 2: number of channels (1..8)
- ADDR_W, 8: address width
- LEN_W, 4: length field width; a job moves len words (0..2^LEN_W-1)
- DATA_W, 8: data word width
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  NCH  per-channel job request, sampled each edge
- src_addr  in  NCH*ADDR_W  channel i source address in bits [i*ADDR_W +: ADDR_W]
- dst_addr  in  NCH*ADDR_W  channel i destination address, same packing
- len  in  NCH*LEN_W  channel i word count, same packing
- rd_en  out  1  memory read strobe
- rd_addr  out  ADDR_W  memory read address
- rd_data  in  DATA_W  memory read data, valid the cycle after rd_en
- wr_en  out  1  memory write strobe
- wr_addr  out  ADDR_W  memory write address
- wr_data  out  DATA_W  memory write data
- busy  out  NCH  channel i has a pending or active job
- done  out  NCH  one-cycle completion pulse per channel

## Operation
- Per-channel pending register. When start[i]=1 and busy[i]=0, latch src/dst/len for channel i and set pending[i]. When busy[i]=1, start[i] is ignored and latched values are not disturbed.
- busy[i] = pending[i] OR (the FSM is active on channel i in READ or WRITE).
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE: if any channel is pending, grant one round-robin, searching from (last_grant+1) mod NCH upward. Load cur_src, cur_dst and cur_cnt from that channel. Go to READ if len≠0, else go to DONE. With nothing pending, stay in IDLE.
- READ: rd_en=1, rd_addr=cur_src. Next state is WRITE.
- WRITE: wr_en=1, wr_addr=cur_dst, wr_data=rd_data (combinational pass-through). Decrement cur_cnt and increment both addresses modulo 2^ADDR_W (wrap 2^ADDR_W-1 → 0). If cur_cnt was 1, clear pending[granted] and go to DONE; otherwise go to READ.
- DONE: done[granted]=1 for this cycle only. Update last_grant to the granted channel. Next state is IDLE.
- A granted job is never pre-empted. A start on another channel only queues.
- rd_en and wr_en are never high in the same cycle.

## Timing
- Reset values: all outputs 0. State=IDLE, pending=0, last_grant=NCH-1, so channel 0 wins first.
- Reset asserted mid-job aborts it. The next cycle has no strobe and no done pulse, and all pending requests are discarded.
- Start sampled at edge of cycle t, with the FSM in IDLE: grant in cycle t+1, first READ in t+2, last WRITE in t+1+2L, done in t+2+2L, IDLE again in t+3+2L.
- busy[i] is high from t+1 through t+1+2L and low in the done cycle. A start in the done cycle is accepted.
- len=0: grant in t+1, done in t+2. There is no memory access.
- Per job, throughput is 2 cycles/word plus 2 overhead cycles (IDLE grant and DONE).
- Simultaneous starts: all are latched in the same edge, then served in round-robin order.

## Test plan
- Single job, NCH=2: ch0 src=0x10, dst=0x40, len=4, start pulse at cycle 0. Required: rd_addr 0x10..0x13 in cycles 2,4,6,8; wr_addr 0x40..0x43 in cycles 3,5,7,9 with memory data copied; done[0] in cycle 10; busy[0] high in cycles 1–9.
- Simultaneous start: ch0 and ch1 both len=2, same cycle. Required: ch0 completes first (done[0]), then ch1 is granted the cycle after the IDLE return; done[1] follows 6 cycles after done[0]. A second simultaneous pair is then served ch0 then ch1 again only if last_grant=1.
- Round-robin fairness: ch0 is re-requested while ch1 is pending during ch0's job. Required: ch1 is served before ch0's second job.
- Address wrap: src=0xFE, dst=0xFF, len=3. Required: rd_addr FE, FF, 00 and wr_addr FF, 00, 01.
- len=0 and ignored start: ch1 len=0 gives done[1] two cycles after start with rd_en and wr_en never high. A start[0] re-asserted while busy[0]=1 with a different src changes nothing.
- Reset mid-transfer: reset in cycle 5 of a len=4 job. Required: all outputs 0 the next cycle, no done pulse, busy=0; a new start afterward grants channel 0 first.
